// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM. It arbitrates between push and
// pop so that at most one RAM access happens per cycle. Read data comes back
// through a two-stage valid pipeline and is registered into pop_data.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop,
    output logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              err_ovf,
    output logic              err_udf,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Count value meaning "completely full" (DEPTH = 2**ADDR_W).
    localparam logic [ADDR_W:0]   DepthCnt = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PtrOne   = 1;
    localparam logic [ADDR_W:0]   CntOne   = 1;

    typedef enum logic {GrantPush, GrantPop} grant_e;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_vpipe;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_pop_valid;
    logic              r_err_ovf;
    logic              r_err_udf;
    grant_e            r_last_grant;

    logic w_push_ok;
    logic w_pop_ok;
    logic w_contend;
    logic w_push_acc;
    logic w_pop_acc;

    assign full  = (r_count == DepthCnt);
    assign empty = (r_count == '0);
    assign count = r_count;

    // Arbitration: round-robin on contention, nothing granted during flush or reset.
    always_comb begin
        w_push_ok  = push & ~full;
        w_pop_ok   = pop & ~empty;
        w_contend  = w_push_ok & w_pop_ok;
        w_push_acc = 1'b0;
        w_pop_acc  = 1'b0;
        if (!flush && !rst) begin
            if (w_contend) begin
                if (r_last_grant == GrantPush) begin
                    w_pop_acc = 1'b1;
                end else begin
                    w_push_acc = 1'b1;
                end
            end else begin
                w_push_acc = w_push_ok;
                w_pop_acc  = w_pop_ok;
            end
        end
    end

    assign push_ready = w_push_acc;
    assign pop_ready  = w_pop_acc;
    assign ram_en     = w_push_acc | w_pop_acc;
    assign ram_we     = w_push_acc;
    assign ram_addr   = w_push_acc ? r_wr_ptr : r_rd_ptr;
    assign ram_din    = push_data;
    assign pop_data   = r_pop_data;
    assign pop_valid  = r_pop_valid;
    assign err_ovf    = r_err_ovf;
    assign err_udf    = r_err_udf;

    // Pointers, occupancy and round-robin state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= GrantPush;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= GrantPush;
        end else begin
            if (w_contend) begin
                r_last_grant <= w_pop_acc ? GrantPop : GrantPush;
            end
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
                r_count  <= r_count + CntOne;
            end else if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
                r_count  <= r_count - CntOne;
            end
        end
    end

    // Sticky error flags; only reset or flush clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else if (flush) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (push && full) begin
                r_err_ovf <= 1'b1;
            end
            if (pop && empty) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    // Read-return pipeline: RAM data is valid one edge after the access edge and
    // captured on the following edge. Flush kills in-flight reads but keeps pop_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe     <= '0;
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
        end else if (flush) begin
            r_vpipe     <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_vpipe     <= {r_vpipe[0], w_pop_acc};
            r_pop_valid <= r_vpipe[1];
            if (r_vpipe[1]) begin
                r_pop_data <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: the driver runs a reference model and
// queues expected read data with its due cycle; a monitor checks every strobe.
module tb_ram_fifo_ctrl;

    localparam int DW = 10;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst;
    logic          push;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          flush;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          err_ovf;
    logic          err_udf;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop        (pop),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .flush      (flush),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .err_ovf    (err_ovf),
        .err_udf    (err_udf),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // RAM model: read data appears on ram_dout one edge after the access edge.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_rd;
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_din;
        if (ram_en && !ram_we) ram_rd <= mem[ram_addr];
        ram_dout <= ram_rd;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] data_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_count, m_wr, m_rd;
    bit m_lg, m_ovf, m_udf;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_wr = 0; m_rd = 0;
        m_lg = 0; m_ovf = 0; m_udf = 0;
        data_q.delete();
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, check combinational/state outputs against the
    // model before the edge, then advance the model after the edge.
    task automatic cycle(input bit p, input logic [DW-1:0] pd, input bit q, input bit f);
        bit pok, qok, e_pr, e_qr;
        exp_t ex;
        push = p; push_data = pd; pop = q; flush = f;
        @(negedge clk);
        pok = p && (m_count != DEPTH);
        qok = q && (m_count != 0);
        e_pr = 0; e_qr = 0;
        if (!f) begin
            if (pok && qok) begin
                if (m_lg == 0) e_qr = 1; else e_pr = 1;
            end else begin
                e_pr = pok; e_qr = qok;
            end
        end
        chk("push_ready", int'(push_ready), int'(e_pr));
        chk("pop_ready", int'(pop_ready), int'(e_qr));
        chk("ram_en", int'(ram_en), int'(e_pr | e_qr));
        chk("ram_we", int'(ram_we), int'(e_pr));
        if (e_pr) begin
            chk("ram_addr_wr", int'(ram_addr), m_wr);
            chk("ram_din", int'(ram_din), int'(pd));
        end
        if (e_qr) chk("ram_addr_rd", int'(ram_addr), m_rd);
        chk("count", int'(count), m_count);
        chk("empty", int'(empty), int'(m_count == 0));
        chk("full", int'(full), int'(m_count == DEPTH));
        chk("err_ovf", int'(err_ovf), int'(m_ovf));
        chk("err_udf", int'(err_udf), int'(m_udf));
        @(posedge clk);
        #1;
        if (f) begin
            model_reset();
        end else begin
            if (p && m_count == DEPTH) m_ovf = 1;
            if (q && m_count == 0) m_udf = 1;
            if (pok && qok) m_lg = e_qr;
            if (e_pr) begin
                data_q.push_back(pd);
                m_wr = (m_wr + 1) % DEPTH;
                m_count++;
            end
            if (e_qr) begin
                ex.d = data_q.pop_front();
                ex.due = cyc + 2;
                exp_q.push_back(ex);
                m_rd = (m_rd + 1) % DEPTH;
                m_count--;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
    endtask

    // Monitor: every pop_valid strobe must match the head of the scoreboard,
    // and no expected strobe may go missing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pop_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", int'(pop_data), int'(e.d));
                    chk("pop_latency", cyc, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("missed_pop_valid", 0, 1);
            end
        end
    end

    initial begin
        rst = 1'b1; push = 1'b1; push_data = '0; pop = 1'b1; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ram_en", int'(ram_en), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_push_ready", int'(push_ready), 0);
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_pop_data", int'(pop_data), 0);
        chk("rst_err_ovf", int'(err_ovf), 0);
        chk("rst_err_udf", int'(err_udf), 0);
        push = 1'b0; pop = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic ordering including an all-ones word.
        cycle(1, 10'h001, 0, 0);
        cycle(1, 10'h002, 0, 0);
        cycle(1, 10'h3FF, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
        idle(4);
        chk("basic_last_data", int'(pop_data), 10'h3FF);

        // Flush right after a pop accept: strobe suppressed, pop_data held.
        cycle(1, 10'h155, 0, 0);
        cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 1);
        idle(4);
        chk("flush_hold_data", int'(pop_data), 10'h3FF);

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0, 0);
        cycle(1, 10'h2AA, 0, 0);
        idle(1);
        for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 0);
        idle(4);

        // Underflow then flush clears the sticky flags.
        cycle(0, '0, 1, 0);
        idle(3);
        cycle(0, '0, 0, 1);
        idle(1);

        // Contention with count = 4: grants pop, push, pop, push.
        for (int i = 0; i < 4; i++) cycle(1, DW'(16 + i), 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, DW'(32 + i), 1, 0);
        idle(1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);
        idle(4);

        // Pointer wrap: 200 in/out, then 100 in/out crossing 255 -> 0.
        cycle(0, '0, 0, 1);
        for (int i = 0; i < 200; i++) cycle(1, DW'((i * 3 + 1) % 1024), 0, 0);
        for (int i = 0; i < 200; i++) cycle(0, '0, 1, 0);
        for (int i = 0; i < 100; i++) cycle(1, DW'((i * 5 + 7) % 1024), 0, 0);
        for (int i = 0; i < 100; i++) cycle(0, '0, 1, 0);
        idle(4);

        // Asynchronous reset one cycle after a pop accept.
        cycle(1, 10'h0A5, 0, 0);
        cycle(1, 10'h05A, 0, 0);
        cycle(0, '0, 1, 0);
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_pop_valid", int'(pop_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        chk("arst_pop_data", int'(pop_data), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
